// File: rtl/ifu_pcgen_if.sv
// ifu_pcgen_if: bus bundle between the BJU, the PC generator and the fetch stage.
//
// Signals:
//   hs_bj4pc_val / hs_pc4bj_rdy  BJU result handshake
//   i_setpc, i_pc, i_pcadd       redirect request, target base and offset
//   hs_pc4if_val / hs_if4pc_rdy  fetch address handshake
//   o_fetch_pc                   fetch address
//   o_redirect                   one-cycle flush pulse after an accepted redirect
//   o_misalign, o_bad_addr       one-cycle misaligned-target flag and offending target
//   i_step2                      (only with CIRNO_PCGEN_RVC_EN) 2-byte increment select
//
// Modports: master = PC generator side, slave = BJU/fetch environment side.
// Optional feature macro: CIRNO_PCGEN_RVC_EN.
interface ifu_pcgen_if;
  logic        hs_bj4pc_val;
  logic        hs_pc4bj_rdy;
  logic        i_setpc;
  logic [31:0] i_pc;
  logic [31:0] i_pcadd;
  logic        hs_pc4if_val;
  logic        hs_if4pc_rdy;
  logic [31:0] o_fetch_pc;
  logic        o_redirect;
  logic        o_misalign;
  logic [31:0] o_bad_addr;
`ifdef CIRNO_PCGEN_RVC_EN
  logic        i_step2;

  modport master (
    input  hs_bj4pc_val, i_setpc, i_pc, i_pcadd, hs_if4pc_rdy, i_step2,
    output hs_pc4bj_rdy, hs_pc4if_val, o_fetch_pc, o_redirect, o_misalign, o_bad_addr
  );
  modport slave (
    output hs_bj4pc_val, i_setpc, i_pc, i_pcadd, hs_if4pc_rdy, i_step2,
    input  hs_pc4bj_rdy, hs_pc4if_val, o_fetch_pc, o_redirect, o_misalign, o_bad_addr
  );
`else
  modport master (
    input  hs_bj4pc_val, i_setpc, i_pc, i_pcadd, hs_if4pc_rdy,
    output hs_pc4bj_rdy, hs_pc4if_val, o_fetch_pc, o_redirect, o_misalign, o_bad_addr
  );
  modport slave (
    output hs_bj4pc_val, i_setpc, i_pc, i_pcadd, hs_if4pc_rdy,
    input  hs_pc4bj_rdy, hs_pc4if_val, o_fetch_pc, o_redirect, o_misalign, o_bad_addr
  );
`endif
endinterface

// File: rtl/ifu_pcgen.sv
// ifu_pcgen: program-counter generator feeding the instruction fetch stage.
//
// Takes redirect results from the branch/jump unit, produces the sequential
// fetch address stream, and parks one redirect in a pending buffer while fetch
// back-pressures so the presented fetch address never changes un-accepted.
// Misaligned targets are reported instead of being followed.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  ifu_pcgen_if.master (BJU handshake, fetch handshake, flags)
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   PC_STEP   sequential increment per accepted fetch
//
// Optional feature macro: CIRNO_PCGEN_RVC_EN (halfword targets, 2-byte step via i_step2).
module ifu_pcgen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic          clk,
  input  logic          rst,
  ifu_pcgen_if.master   bus
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_PEND
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_fetch_pc, w_fetch_pc_next;
  logic [31:0] r_pend_pc, w_pend_pc_next;
  logic [31:0] r_bad_addr, w_bad_addr_next;
  logic        r_redirect, w_redirect_next;
  logic        r_misalign, w_misalign_next;

  logic        w_if_val, w_bj_rdy, w_bj_acc, w_if_acc, w_take, w_mis;
  logic [31:0] w_sum, w_tgt, w_step;

  assign w_sum = bus.i_pc + bus.i_pcadd;
  assign w_tgt = w_sum & ~32'h1;   // bit0 never addresses an instruction

`ifdef CIRNO_PCGEN_RVC_EN
  assign w_mis  = 1'b0;
  assign w_step = bus.i_step2 ? 32'd2 : PC_STEP;
`else
  assign w_mis  = w_tgt[1];
  assign w_step = PC_STEP;
`endif

  // Handshake readiness depends on state only, so there is no path from
  // the partner's valid/ready back into our own valid/ready.
  assign w_if_val = (r_state == S_RUN) || (r_state == S_PEND);
  assign w_bj_rdy = (r_state == S_RUN);

  assign w_bj_acc = bus.hs_bj4pc_val & w_bj_rdy;
  assign w_if_acc = w_if_val & bus.hs_if4pc_rdy;
  assign w_take   = w_bj_acc & bus.i_setpc;

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_pend_pc_next  = r_pend_pc;
    w_bad_addr_next = r_bad_addr;
    w_redirect_next = 1'b0;
    w_misalign_next = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_take && !w_mis) begin
          w_redirect_next = 1'b1;
          if (w_if_acc) begin
            w_fetch_pc_next = w_tgt;
          end else begin
            // Fetch is stalled: hold the address, remember the target.
            w_pend_pc_next = w_tgt;
            w_state_next   = S_PEND;
          end
        end else begin
          if (w_take) begin
            w_misalign_next = 1'b1;
            w_bad_addr_next = w_tgt;
          end
          if (w_if_acc) begin
            w_fetch_pc_next = r_fetch_pc + w_step;
          end
        end
      end
      S_PEND: begin
        if (w_if_acc) begin
          w_fetch_pc_next = r_pend_pc;
          w_pend_pc_next  = '0;
          w_state_next    = S_RUN;
        end
      end
      default: begin
        w_state_next = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= '0;
      r_bad_addr <= '0;
      r_redirect <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_pend_pc  <= w_pend_pc_next;
      r_bad_addr <= w_bad_addr_next;
      r_redirect <= w_redirect_next;
      r_misalign <= w_misalign_next;
    end
  end

  assign bus.hs_pc4if_val = w_if_val;
  assign bus.hs_pc4bj_rdy = w_bj_rdy;
  assign bus.o_fetch_pc   = r_fetch_pc;
  assign bus.o_redirect   = r_redirect;
  assign bus.o_misalign   = r_misalign;
  assign bus.o_bad_addr   = r_bad_addr;

endmodule

// File: tb/tb_ifu_pcgen.sv
// tb_ifu_pcgen: directed, table-driven bench for ifu_pcgen (default build).
// Each table row gives the inputs driven during one cycle and the outputs
// expected in that same cycle (before the following rising edge).
module tb_ifu_pcgen;

  logic clk;
  logic rst;

  ifu_pcgen_if bus ();

  ifu_pcgen u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_rdy;
    logic        bj_val;
    logic        setpc;
    logic [31:0] pc;
    logic [31:0] pcadd;
    logic        e_val;
    logic        e_bjrdy;
    logic [31:0] e_pc;
    logic        e_redir;
    logic        e_mis;
    logic [31:0] e_bad;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int n_total;
  int n_pass;

  function automatic vec_t mk(logic if_rdy, logic bj_val, logic setpc,
                              logic [31:0] pc, logic [31:0] pcadd,
                              logic e_val, logic e_bjrdy, logic [31:0] e_pc,
                              logic e_redir, logic e_mis, logic [31:0] e_bad);
    vec_t v;
    v.if_rdy = if_rdy;  v.bj_val = bj_val;   v.setpc = setpc;
    v.pc     = pc;      v.pcadd  = pcadd;
    v.e_val  = e_val;   v.e_bjrdy = e_bjrdy; v.e_pc = e_pc;
    v.e_redir = e_redir; v.e_mis = e_mis;    v.e_bad = e_bad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic if_rdy, input logic bj_val, input logic setpc,
                       input logic [31:0] pc, input logic [31:0] pcadd);
    bus.hs_if4pc_rdy = if_rdy;
    bus.hs_bj4pc_val = bj_val;
    bus.i_setpc      = setpc;
    bus.i_pc         = pc;
    bus.i_pcadd      = pcadd;
  endtask

  task automatic chk_all(input string tag, input logic e_val, input logic e_bjrdy,
                         input logic [31:0] e_pc, input logic e_redir,
                         input logic e_mis, input logic [31:0] e_bad);
    chk({tag, "_val"},   32'(bus.hs_pc4if_val), 32'(e_val));
    chk({tag, "_bjrdy"}, 32'(bus.hs_pc4bj_rdy), 32'(e_bjrdy));
    chk({tag, "_pc"},    bus.o_fetch_pc, e_pc);
    chk({tag, "_redir"}, 32'(bus.o_redirect), 32'(e_redir));
    chk({tag, "_mis"},   32'(bus.o_misalign), 32'(e_mis));
    chk({tag, "_bad"},   bus.o_bad_addr, e_bad);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    //               if bj sp  i_pc          i_pcadd     | val rdy pc          red mis bad
    vecs[0]  = mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 32'h0);   // BOOT
    vecs[1]  = mk(1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0,        0, 0, 32'h0);
    vecs[2]  = mk(1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h4,        0, 0, 32'h0);
    vecs[3]  = mk(1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h8,        0, 0, 32'h0);
    vecs[4]  = mk(1, 1, 1, 32'h100,      32'h20,       1, 1, 32'hC,        0, 0, 32'h0);   // redirect + fetch
    vecs[5]  = mk(1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h120,      1, 0, 32'h0);
    vecs[6]  = mk(1, 1, 1, 32'h40,       32'h0,        1, 1, 32'h124,      0, 0, 32'h0);   // go to 0x40
    vecs[7]  = mk(0, 1, 1, 32'h100,      32'h100,      1, 1, 32'h40,       1, 0, 32'h0);   // redirect, stalled
    vecs[8]  = mk(0, 1, 1, 32'h500,      32'h0,        1, 0, 32'h40,       1, 0, 32'h0);   // PEND, 2nd redirect ignored
    vecs[9]  = mk(1, 0, 0, 32'h0,        32'h0,        1, 0, 32'h40,       0, 0, 32'h0);   // PEND exit
    vecs[10] = mk(1, 1, 1, 32'h301,      32'h0,        1, 1, 32'h200,      0, 0, 32'h0);   // JALR bit0
    vecs[11] = mk(1, 1, 1, 32'h100,      32'h6,        1, 1, 32'h300,      1, 0, 32'h0);   // misaligned
    vecs[12] = mk(1, 1, 0, 32'h999,      32'h0,        1, 1, 32'h304,      0, 1, 32'h106); // not taken
    vecs[13] = mk(1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h308,      0, 0, 32'h106);
    vecs[14] = mk(0, 1, 1, 32'h2,        32'h0,        1, 1, 32'h30C,      0, 0, 32'h106); // misaligned, stalled
    vecs[15] = mk(1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h30C,      0, 1, 32'h2);
    vecs[16] = mk(1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h310,      0, 0, 32'h2);

`ifdef CIRNO_PCGEN_RVC_EN
    bus.i_step2 = 1'b0;
`endif
    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].if_rdy, vecs[i].bj_val, vecs[i].setpc, vecs[i].pc, vecs[i].pcadd);
      #1;
      $display("row %0d: pc=0x%08h val=%0b bjrdy=%0b redir=%0b mis=%0b bad=0x%08h",
               i, bus.o_fetch_pc, bus.hs_pc4if_val, bus.hs_pc4bj_rdy,
               bus.o_redirect, bus.o_misalign, bus.o_bad_addr);
      chk_all($sformatf("row%0d", i), vecs[i].e_val, vecs[i].e_bjrdy, vecs[i].e_pc,
              vecs[i].e_redir, vecs[i].e_mis, vecs[i].e_bad);
      @(negedge clk);
    end

    // Wrap-around: jump to 0xFFFF_FFFC, next sequential fetch is 0.
    drive(1, 1, 1, 32'hFFFF_FFF0, 32'hC);
    @(negedge clk);
    $display("wrap0: pc=0x%08h", bus.o_fetch_pc);
    chk_all("wrap0", 1, 1, 32'hFFFF_FFFC, 1, 0, 32'h2);
    drive(1, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    $display("wrap1: pc=0x%08h", bus.o_fetch_pc);
    chk_all("wrap1", 1, 1, 32'h0, 0, 0, 32'h2);

    // Reset while a redirect is pending: the buffered target must vanish.
    drive(0, 1, 1, 32'h800, 32'h0);
    @(negedge clk);
    $display("pend: pc=0x%08h bjrdy=%0b", bus.o_fetch_pc, bus.hs_pc4bj_rdy);
    chk_all("pend", 1, 0, 32'h0, 1, 0, 32'h2);
    drive(0, 0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    $display("rst: pc=0x%08h val=%0b", bus.o_fetch_pc, bus.hs_pc4if_val);
    chk_all("rst", 0, 0, 32'h0, 0, 0, 32'h0);
    rst = 1'b0;
    drive(1, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    $display("boot: pc=0x%08h val=%0b", bus.o_fetch_pc, bus.hs_pc4if_val);
    chk_all("boot", 1, 1, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    $display("post: pc=0x%08h", bus.o_fetch_pc);
    chk_all("post", 1, 1, 32'h4, 0, 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifu_pcgen.md
Name: ifu_pcgen

Overview:
- Program-counter generator sitting directly downstream of the branch/jump unit; consumes its redirect outputs (setpc, base pc, pc offset).
- Produces the fetch address stream for the instruction fetch stage.
- Holds a one-entry pending-redirect buffer so the fetch address stays stable while fetch back-pressures.
- Flags misaligned jump/branch targets instead of redirecting to them.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, sequential increment per accepted fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
hs_bj4pc_val  in  1  BJU result valid
hs_pc4bj_rdy  out  1  pcgen can accept a BJU result
i_setpc  in  1  redirect requested (qualified by hs_bj4pc_val)
i_pc  in  32  target base (rs1 for JALR, instruction pc otherwise)
i_pcadd  in  32  target offset (immediate)
hs_pc4if_val  out  1  fetch address valid
hs_if4pc_rdy  in  1  fetch accepts address
o_fetch_pc  out  32  fetch address
o_redirect  out  1  one-cycle pulse: younger in-flight instructions are wrong-path, flush
o_misalign  out  1  one-cycle pulse: rejected target was misaligned
o_bad_addr  out  32  offending target, valid with o_misalign

Behaviour:
- Clock/reset: one clock clk; rst synchronous active-high, sampled on rising edge.
- Reset values: state=BOOT, o_fetch_pc=RESET_PC, hs_pc4if_val=0, o_redirect=0, o_misalign=0, o_bad_addr=0, pending buffer empty.
- Target computation: tgt = (i_pc + i_pcadd) mod 2^32, with bit0 forced to 0.
- Misaligned target: tgt[1]=1 (see the optional feature).
- Handshakes:
  - BJU accept = hs_bj4pc_val & hs_pc4bj_rdy.
  - Fetch accept = hs_pc4if_val & hs_if4pc_rdy.
- States:
  - BOOT: entered on reset. Next cycle goes to RUN. hs_pc4if_val=0, hs_pc4bj_rdy=0.
  - RUN:
    - hs_pc4if_val=1, hs_pc4bj_rdy=1.
    - Fetch accept with no redirect: o_fetch_pc += PC_STEP.
    - Redirect accepted (i_setpc=1, aligned):
      - With fetch accept in the same cycle: o_fetch_pc<=tgt, stay RUN.
      - Without fetch accept: tgt goes into the pending buffer, go to PEND. o_fetch_pc unchanged.
  - PEND:
    - hs_pc4if_val=1, o_fetch_pc held stable, hs_pc4bj_rdy=0.
    - On fetch accept: o_fetch_pc<=pending, buffer cleared, go to RUN.
- o_redirect: registered. Asserted the cycle after an accepted aligned redirect, for exactly 1 cycle.
- Fetch that completes in the redirect-accept cycle, or the PEND-exit cycle: counts as issued. It is the wrong-path instruction downstream flushes via o_redirect.
- Not-taken (accepted with i_setpc=0): no state change, no pulse.
- Misaligned accepted redirect:
  - No pc change, no o_redirect.
  - o_misalign=1 and o_bad_addr=tgt the next cycle.
  - Stay in current state.
  - o_bad_addr holds its value until the next misalign.
- Redirect always takes priority over sequential increment. Only one pending redirect can exist; a second is back-pressured by rdy=0.
- Stability rule: while hs_pc4if_val=1 and no fetch accept, o_fetch_pc must not change.
- Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no flag.
- rst during PEND or mid-handshake: pending buffer discarded, back to BOOT with reset values next cycle.

Optional Feature:
- Macro: CIRNO_PCGEN_RVC_EN.
- Defined:
  - Targets need only halfword alignment. tgt[1] is not checked; o_misalign is tied to 0 and o_bad_addr to 0.
  - Input i_step2 (1 bit) is added. On fetch accept, the increment is 2 when i_step2=1, else PC_STEP.
- Undefined:
  - Word alignment is required; tgt[1]=1 raises o_misalign.
  - The increment is always PC_STEP; no i_step2 port.

Test Plan:
- Reset then rdy tied 1 -> val=0 for one cycle, then o_fetch_pc 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- In RUN, fetch rdy=1, BJU val=1 setpc=1 i_pc=0x100 i_pcadd=0x20 -> next o_fetch_pc=0x120, o_redirect=1 for one cycle, then 0x124.
- Fetch rdy=0 with fetch pc 0x40, redirect to 0x200 -> o_fetch_pc stays 0x40, hs_pc4bj_rdy=0. Then rdy=1 -> next o_fetch_pc=0x200, rdy back to 1.
- JALR i_pc=0x301 i_pcadd=0 -> o_fetch_pc=0x300 (bit0 cleared).
- i_pc=0x100 i_pcadd=0x6, macro off -> o_misalign=1, o_bad_addr=0x106, pc continues sequentially, no o_redirect. Macro on -> redirect to 0x106.
- setpc=0 accepted -> pc sequence unchanged, no pulses. rst asserted during PEND -> next cycle val=0, pc=RESET_PC, buffer empty.
